// File: rtl/datapath_seq_n.sv
// ---------------------------------------------------------------------------
// datapath_seq_n
//
// Purpose:
//   N-bit accumulator-style CPU datapath with a built-in micro-sequencer.
//   It holds a NUM_REGS-entry register file, an A/G ALU pair and a STORE/LED
//   register. The instruction set is:
//     LOAD  Rx <= data
//     MOV   Rx <= Ry
//     ADD   Rx <= Rx + Ry
//     SUB   Rx <= Rx - Ry
//     STORE LEDs <= Rx
//     AND   Rx <= Rx & Ry
//     OR    Rx <= Rx | Ry
//     XOR   Rx <= Rx ^ Ry
//   The block takes one instruction at a time over a valid/ready handshake.
//   It pulses done for one cycle after the instruction's final write.
//
// Configuration:
//   DATAPATH_SEQ_FLAGS_EN  when defined, zero/carry flags are updated at T3
//                          of ALU ops. When undefined, both flags are tied
//                          to 0.
//
// Parameters:
//   WIDTH     datapath/bus/register width (2..32)
//   NUM_REGS  number of general registers, power of 2 (2..16)
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   instr_valid  instr/data_in valid (held until accepted)
//   instr_ready  high only in IDLE
//   instr        {op[2:0], rx[RSEL-1:0], ry[RSEL-1:0]}
//   data_in      immediate operand for LOAD
//   done         one-cycle pulse after the final write of an instruction
//   bus_wires    internal bus value, 0 in IDLE
//   LEDs         STORE register
//   flag_z       zero flag
//   flag_c       carry/borrow flag
// ---------------------------------------------------------------------------
module datapath_seq_n #(
    parameter  int WIDTH    = 4,
    parameter  int NUM_REGS = 4,
    localparam int RSEL     = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [3+2*RSEL-1:0]   instr,
    input  logic [WIDTH-1:0]      data_in,
    output logic                  done,
    output logic [WIDTH-1:0]      bus_wires,
    output logic [WIDTH-1:0]      LEDs,
    output logic                  flag_z,
    output logic                  flag_c
);

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_MOV   = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_STORE = 3'b100;
    localparam logic [2:0] OP_AND   = 3'b101;
    localparam logic [2:0] OP_OR    = 3'b110;
    localparam logic [2:0] OP_XOR   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_T3   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [2:0]        r_op;
    logic [RSEL-1:0]   r_rx;
    logic [RSEL-1:0]   r_ry;
    logic [WIDTH-1:0]  r_data;

    logic [WIDTH-1:0]  r_regs [NUM_REGS];
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_g;
    logic [WIDTH-1:0]  r_leds;
    logic              r_done;

    logic              w_accept;
    logic              w_is_alu;
    logic [WIDTH-1:0]  w_bus;

    // ALU result, modulo 2^WIDTH
    function automatic logic [WIDTH-1:0] alu_result(input logic [2:0]       op,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] res;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            default: res = b;
        endcase
        return res;
    endfunction

`ifdef DATAPATH_SEQ_FLAGS_EN
    // Carry-out for ADD, borrow for SUB, 0 for the bitwise ops
    function automatic logic alu_carry(input logic [2:0]       op,
                                       input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
        logic [WIDTH:0] sum;
        logic           c;
        sum = {1'b0, a} + {1'b0, b};
        case (op)
            OP_ADD:  c = sum[WIDTH];
            OP_SUB:  c = (a < b);
            default: c = 1'b0;
        endcase
        return c;
    endfunction
`endif

    assign w_accept = instr_valid && (r_state == S_IDLE);
    assign w_is_alu = (r_op != OP_LOAD) && (r_op != OP_MOV) && (r_op != OP_STORE);

    // Sequencer: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Sequencer: next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (instr_valid) w_next_state = S_T1;
            S_T1:    w_next_state = w_is_alu ? S_T2 : S_IDLE;
            S_T2:    w_next_state = S_T3;
            S_T3:    w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Sequencer: outputs (ready and bus mux)
    always_comb begin
        instr_ready = (r_state == S_IDLE);
        w_bus       = '0;
        case (r_state)
            S_T1: begin
                case (r_op)
                    OP_LOAD: w_bus = r_data;
                    OP_MOV:  w_bus = r_regs[r_ry];
                    default: w_bus = r_regs[r_rx];   // STORE and ALU first operand
                endcase
            end
            S_T2:    w_bus = r_regs[r_ry];
            S_T3:    w_bus = r_g;
            default: w_bus = '0;
        endcase
    end

    // Instruction latch: captured only on the accept edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op   <= OP_LOAD;
            r_rx   <= '0;
            r_ry   <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_op   <= instr[2*RSEL+2:2*RSEL];
            r_rx   <= instr[2*RSEL-1:RSEL];
            r_ry   <= instr[RSEL-1:0];
            r_data <= data_in;
        end
    end

    // Register file, A/G and LED register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_a    <= '0;
            r_g    <= '0;
            r_leds <= '0;
        end else begin
            case (r_state)
                S_T1: begin
                    if (r_op == OP_STORE) begin
                        r_leds <= w_bus;
                    end else if (w_is_alu) begin
                        r_a <= w_bus;
                    end else begin
                        r_regs[r_rx] <= w_bus;
                    end
                end
                S_T2:    r_g <= alu_result(r_op, r_a, w_bus);
                S_T3:    r_regs[r_rx] <= w_bus;
                default: ;
            endcase
        end
    end

    // done rises the cycle after the final write; the FSM is already back in IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= ((r_state == S_T1) && !w_is_alu) || (r_state == S_T3);
        end
    end

`ifdef DATAPATH_SEQ_FLAGS_EN
    logic r_gc;
    logic r_flag_z;
    logic r_flag_c;

    // Carry is captured alongside G at T2 and published with the result at T3
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gc     <= 1'b0;
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
        end else begin
            if (r_state == S_T2) begin
                r_gc <= alu_carry(r_op, r_a, w_bus);
            end
            if (r_state == S_T3) begin
                r_flag_z <= (r_g == '0);
                r_flag_c <= r_gc;
            end
        end
    end

    assign flag_z = r_flag_z;
    assign flag_c = r_flag_c;
`else
    assign flag_z = 1'b0;
    assign flag_c = 1'b0;
`endif

    assign bus_wires = w_bus;
    assign LEDs      = r_leds;
    assign done      = r_done;

endmodule

// File: tb/tb_datapath_seq_n.sv
module tb_datapath_seq_n;

    localparam int W  = 4;
    localparam int NR = 4;

    localparam logic [2:0] LOAD  = 3'b000;
    localparam logic [2:0] MOV   = 3'b001;
    localparam logic [2:0] ADD   = 3'b010;
    localparam logic [2:0] SUB   = 3'b011;
    localparam logic [2:0] STORE = 3'b100;
    localparam logic [2:0] AND_  = 3'b101;
    localparam logic [2:0] OR_   = 3'b110;
    localparam logic [2:0] XOR_  = 3'b111;

    logic         clk;
    logic         reset;
    logic         instr_valid;
    logic         instr_ready;
    logic [6:0]   instr;
    logic [W-1:0] data_in;
    logic         done;
    logic [W-1:0] bus_wires;
    logic [W-1:0] LEDs;
    logic         flag_z;
    logic         flag_c;

    datapath_seq_n #(.WIDTH(W), .NUM_REGS(NR)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .data_in     (data_in),
        .done        (done),
        .bus_wires   (bus_wires),
        .LEDs        (LEDs),
        .flag_z      (flag_z),
        .flag_c      (flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    int m_r [NR];
    int m_leds;
    int m_z;
    int m_c;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_z();
`ifdef DATAPATH_SEQ_FLAGS_EN
        return m_z;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_c();
`ifdef DATAPATH_SEQ_FLAGS_EN
        return m_c;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_r[i] = 0;
        m_leds = 0;
        m_z    = 0;
        m_c    = 0;
    endtask

    // Issue one instruction, follow it through every busy cycle, update the model.
    // hold=1 leaves instr_valid asserted with the same instruction throughout.
    task automatic exec(input logic [2:0] op, input logic [1:0] rx, input logic [1:0] ry,
                        input logic [W-1:0] d, input bit hold);
        int a, b, res, c, lat, k;
        bit alu;
        a   = m_r[rx];
        b   = m_r[ry];
        alu = !(op == LOAD || op == MOV || op == STORE);
        lat = alu ? 3 : 1;
        c   = 0;
        case (op)
            ADD:  begin res = (a + b) % 16; c = (a + b > 15) ? 1 : 0; end
            SUB:  begin res = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
            AND_: res = a & b;
            OR_:  res = a | b;
            XOR_: res = a ^ b;
            default: res = 0;
        endcase

        k = 0;
        while (instr_ready !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        chk("ready_before_accept", 32'(instr_ready), 1);
        instr_valid = 1'b1;
        instr       = {op, rx, ry};
        data_in     = d;
        step();

        for (int cyc = 0; cyc < lat; cyc++) begin
            chk("busy_done_low", 32'(done), 0);
            chk("busy_ready_low", 32'(instr_ready), 0);
            if (cyc == 0) begin
                case (op)
                    LOAD:    chk("bus_t1_load", 32'(bus_wires), 32'(d));
                    MOV:     chk("bus_t1_mov", 32'(bus_wires), b);
                    default: chk("bus_t1_rx", 32'(bus_wires), a);
                endcase
            end else if (cyc == 1) begin
                chk("bus_t2_ry", 32'(bus_wires), b);
            end else begin
                chk("bus_t3_g", 32'(bus_wires), res);
            end
            if (!hold) begin
                instr_valid = 1'($urandom);
                instr       = 7'($urandom);
                data_in     = 4'($urandom);
            end
            step();
        end
        if (!hold) instr_valid = 1'b0;

        case (op)
            LOAD:    m_r[rx] = int'(d);
            MOV:     m_r[rx] = b;
            STORE:   m_leds  = a;
            default: begin
                m_r[rx] = res;
                m_z     = (res == 0) ? 1 : 0;
                m_c     = c;
            end
        endcase

        chk("done_pulse", 32'(done), 1);
        chk("idle_ready", 32'(instr_ready), 1);
        chk("idle_bus_zero", 32'(bus_wires), 0);
        chk("leds", 32'(LEDs), m_leds);
        chk("flag_z", 32'(flag_z), exp_z());
        chk("flag_c", 32'(flag_c), exp_c());
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        data_in     = '0;
        model_reset();

        // Reset state
        step();
        chk("rst_ready", 32'(instr_ready), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_leds", 32'(LEDs), 0);
        chk("rst_bus", 32'(bus_wires), 0);
        chk("rst_flag_z", 32'(flag_z), 0);
        chk("rst_flag_c", 32'(flag_c), 0);
        step();
        reset = 1'b0;
        step();

        // LOAD/LOAD/ADD/STORE
        exec(LOAD, 2'd0, 2'd0, 4'd5, 1'b0);
        exec(LOAD, 2'd1, 2'd0, 4'd3, 1'b0);
        exec(ADD, 2'd0, 2'd1, 4'd0, 1'b0);
        exec(STORE, 2'd0, 2'd0, 4'd0, 1'b0);
        chk("dir_add_leds", 32'(LEDs), 8);

        // SUB wraps with borrow
        exec(LOAD, 2'd2, 2'd0, 4'd2, 1'b0);
        exec(LOAD, 2'd3, 2'd0, 4'd5, 1'b0);
        exec(SUB, 2'd2, 2'd3, 4'd0, 1'b0);
`ifdef DATAPATH_SEQ_FLAGS_EN
        chk("dir_sub_c", 32'(flag_c), 1);
        chk("dir_sub_z", 32'(flag_z), 0);
`endif
        exec(STORE, 2'd2, 2'd0, 4'd0, 1'b0);
        chk("dir_sub_leds", 32'(LEDs), 4'hD);

        // ADD overflow to zero
        exec(LOAD, 2'd0, 2'd0, 4'hF, 1'b0);
        exec(LOAD, 2'd1, 2'd0, 4'h1, 1'b0);
        exec(ADD, 2'd0, 2'd1, 4'd0, 1'b0);
`ifdef DATAPATH_SEQ_FLAGS_EN
        chk("dir_ovf_z", 32'(flag_z), 1);
        chk("dir_ovf_c", 32'(flag_c), 1);
`else
        chk("dir_ovf_z_off", 32'(flag_z), 0);
        chk("dir_ovf_c_off", 32'(flag_c), 0);
`endif
        exec(STORE, 2'd0, 2'd0, 4'd0, 1'b0);
        chk("dir_ovf_leds", 32'(LEDs), 0);
        // flags hold through simple ops
        exec(LOAD, 2'd3, 2'd0, 4'h6, 1'b0);
        exec(MOV, 2'd2, 2'd3, 4'd0, 1'b0);

        // Back-to-back ADD with instr_valid held high
        exec(ADD, 2'd0, 2'd1, 4'd0, 1'b1);
        exec(ADD, 2'd0, 2'd1, 4'd0, 1'b0);
        exec(STORE, 2'd0, 2'd0, 4'd0, 1'b0);
        chk("dir_hold_leds", 32'(LEDs), 2);

        // rx==ry cases and bitwise ops
        exec(MOV, 2'd3, 2'd3, 4'd0, 1'b0);
        exec(LOAD, 2'd1, 2'd0, 4'hA, 1'b0);
        exec(ADD, 2'd1, 2'd1, 4'd0, 1'b0);
        exec(LOAD, 2'd1, 2'd0, 4'hA, 1'b0);
        exec(XOR_, 2'd1, 2'd1, 4'd0, 1'b0);
        exec(STORE, 2'd1, 2'd0, 4'd0, 1'b0);
        chk("dir_xor_leds", 32'(LEDs), 0);
        exec(LOAD, 2'd2, 2'd0, 4'hC, 1'b0);
        exec(LOAD, 2'd3, 2'd0, 4'h6, 1'b0);
        exec(AND_, 2'd2, 2'd3, 4'd0, 1'b0);
        exec(STORE, 2'd2, 2'd0, 4'd0, 1'b0);
        chk("dir_and_leds", 32'(LEDs), 4'h4);
        exec(LOAD, 2'd2, 2'd0, 4'hC, 1'b0);
        exec(OR_, 2'd2, 2'd3, 4'd0, 1'b0);
        exec(STORE, 2'd2, 2'd0, 4'd0, 1'b0);
        chk("dir_or_leds", 32'(LEDs), 4'hE);

        // Reset during T2 of ADD R0,R1
        exec(LOAD, 2'd0, 2'd0, 4'h7, 1'b0);
        exec(STORE, 2'd0, 2'd0, 4'd0, 1'b0);
        instr_valid = 1'b1;
        instr       = {ADD, 2'd0, 2'd1};
        step();
        instr_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("midrst_ready", 32'(instr_ready), 1);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_leds", 32'(LEDs), 0);
        chk("midrst_bus", 32'(bus_wires), 0);
        step();
        chk("midrst_done_hold", 32'(done), 0);
        reset = 1'b0;
        model_reset();
        step();
        chk("postrst_done", 32'(done), 0);
        step();
        chk("postrst_done2", 32'(done), 0);
        for (int i = 0; i < NR; i++) begin
            exec(STORE, 2'(i), 2'd0, 4'd0, 1'b0);
        end

        // Randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            exec(3'($urandom), 2'($urandom), 2'($urandom), 4'($urandom), 1'b0);
        end
        for (int i = 0; i < NR; i++) begin
            exec(STORE, 2'(i), 2'd0, 4'd0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
